// File: rtl/mem_port_sched.sv
// Arbiter for the shared data-memory port: WB store > MEM load > debug read,
// with a bounded deferral after which the debug read takes the port for one cycle.
module mem_port_sched #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int DBG_MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              in_RST,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_wr_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    input  logic              cpu_wr_half,
    input  logic              cpu_rd_req,
    input  logic [ADDR_W-1:0] cpu_rd_addr,
    output logic [DATA_W-1:0] cpu_rd_data,
    output logic              hold_front,
    output logic              hold_wb,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_data,
    output logic              mem_we,
    output logic              mem_half,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       stall_cnt
);

    localparam int CNT_W = (DBG_MAX_WAIT > 1) ? $clog2(DBG_MAX_WAIT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2
    } state_t;

    state_t            state_q,    state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0] dbg_addr_q, dbg_addr_d;
    logic [DATA_W-1:0] dbg_data_q, dbg_data_d;
    logic              dbg_ack_q,  dbg_ack_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;
    logic              dbg_gnt;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Port ownership and pipeline holds
    always_comb begin
        dbg_gnt    = 1'b0;
        mem_addr   = cpu_rd_addr;
        mem_we     = 1'b0;
        mem_half   = 1'b0;
        hold_front = 1'b0;
        hold_wb    = 1'b0;
        if (state_q == ST_FORCE) begin
            dbg_gnt    = 1'b1;
            mem_addr   = dbg_addr_q;
            hold_front = cpu_rd_req | cpu_we;
            hold_wb    = cpu_we;
        end else if (cpu_we) begin
            // A colliding load is frozen and retried; the store retires now.
            mem_addr   = cpu_wr_addr;
            mem_we     = 1'b1;
            mem_half   = cpu_wr_half;
            hold_front = cpu_rd_req;
        end else if (cpu_rd_req) begin
            mem_addr   = cpu_rd_addr;
        end else if (state_q == ST_WAIT) begin
            dbg_gnt    = 1'b1;
            mem_addr   = dbg_addr_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        dbg_addr_d  = dbg_addr_q;
        dbg_data_d  = dbg_data_q;
        dbg_ack_d   = 1'b0;
        stall_cnt_d = hold_front ? sat_inc16(stall_cnt_q) : stall_cnt_q;
        if (dbg_gnt) begin
            dbg_data_d = mem_rdata;
            dbg_ack_d  = 1'b1;
            wait_cnt_d = '0;
            state_d    = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (dbg_req) begin
                        dbg_addr_d = dbg_addr;
                        wait_cnt_d = '0;
                        state_d    = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Not granted here means the CPU held the port this cycle.
                    if (wait_cnt_q == CNT_W'(DBG_MAX_WAIT - 1)) begin
                        wait_cnt_d = '0;
                        state_d    = ST_FORCE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge in_RST) begin
        if (!in_RST) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            dbg_addr_q  <= '0;
            dbg_data_q  <= '0;
            dbg_ack_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            dbg_addr_q  <= dbg_addr_d;
            dbg_data_q  <= dbg_data_d;
            dbg_ack_q   <= dbg_ack_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign cpu_rd_data = mem_rdata;
    assign mem_wdata   = cpu_wr_data;
    assign dbg_ack     = dbg_ack_q;
    assign dbg_data    = dbg_data_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_mem_port_sched.sv
// Scoreboard bench for mem_port_sched: a transaction-level model predicts each
// cycle's port decision and debug replies; a negedge monitor compares.
module tb_mem_port_sched;
    localparam int ADDR_W       = 12;
    localparam int DATA_W       = 32;
    localparam int DBG_MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              in_RST = 1'b0;
    logic              cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_wr_addr = '0;
    logic [DATA_W-1:0] cpu_wr_data = '0;
    logic              cpu_wr_half = 1'b0;
    logic              cpu_rd_req = 1'b0;
    logic [ADDR_W-1:0] cpu_rd_addr = '0;
    logic [DATA_W-1:0] cpu_rd_data;
    logic              hold_front, hold_wb;
    logic              dbg_req = 1'b0;
    logic [ADDR_W-1:0] dbg_addr = '0;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_data;
    logic              mem_we, mem_half;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [15:0]       stall_cnt;

    mem_port_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DBG_MAX_WAIT(DBG_MAX_WAIT)) dut (
        .clk(clk), .in_RST(in_RST),
        .cpu_we(cpu_we), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
        .cpu_wr_half(cpu_wr_half), .cpu_rd_req(cpu_rd_req), .cpu_rd_addr(cpu_rd_addr),
        .cpu_rd_data(cpu_rd_data), .hold_front(hold_front), .hold_wb(hold_wb),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack), .dbg_data(dbg_data),
        .mem_we(mem_we), .mem_half(mem_half), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Data memory seen by the DUT (halfword writes replace the low 16 bits).
    bit [DATA_W-1:0] phys [4096];
    assign mem_rdata = phys[mem_addr];
    always @(posedge clk)
        if (mem_we)
            phys[mem_addr] <= mem_half ? {phys[mem_addr][31:16], mem_wdata[15:0]} : mem_wdata;

    typedef struct {
        logic              hf, hwb, we, half;
        logic              addr_care, rd_care;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] rd_data, wdata, dbg_data;
        logic              ack;
        logic [15:0]       stall;
    } exp_t;

    exp_t              exp_q [$];
    logic [DATA_W-1:0] dbg_q [$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pending debug read with a deferral count
    bit [DATA_W-1:0]   ref_mem [4096];
    bit                m_pend, m_force, m_ack;
    int                m_defer, m_stall;
    logic [ADDR_W-1:0] m_daddr;
    logic [DATA_W-1:0] m_ddata;
    bit                rst_lvl;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_force = 0; m_ack = 0; m_defer = 0; m_stall = 0;
        m_daddr = '0; m_ddata = '0;
        dbg_q.delete();
    endtask

    task automatic model_step(input bit apply);
        exp_t e;
        bit   serve;
        e.hf = 0; e.hwb = 0; e.we = 0; e.half = 0;
        e.addr_care = 0; e.rd_care = 0; e.addr = '0; e.rd_data = '0;
        e.wdata = cpu_wr_data; e.ack = m_ack; e.dbg_data = m_ddata;
        e.stall = m_stall[15:0];
        serve = 0;
        if (m_force) begin
            e.addr_care = 1; e.addr = m_daddr;
            e.hf = cpu_we | cpu_rd_req; e.hwb = cpu_we;
            serve = 1;
        end else if (cpu_we) begin
            e.addr_care = 1; e.addr = cpu_wr_addr;
            e.we = 1; e.half = cpu_wr_half; e.hf = cpu_rd_req;
        end else if (cpu_rd_req) begin
            e.addr_care = 1; e.addr = cpu_rd_addr;
            e.rd_care = 1; e.rd_data = ref_mem[cpu_rd_addr];
        end else if (m_pend) begin
            e.addr_care = 1; e.addr = m_daddr;
            serve = 1;
        end
        exp_q.push_back(e);
        if (apply) begin
            m_ack = serve;
            if (serve) begin
                m_ddata = ref_mem[m_daddr];
                dbg_q.push_back(m_ddata);
                m_pend = 0; m_force = 0; m_defer = 0;
            end else if (!m_pend) begin
                if (dbg_req) begin
                    m_pend = 1; m_daddr = dbg_addr; m_defer = 0;
                end
            end else begin
                m_defer++;
                if (m_defer == DBG_MAX_WAIT) m_force = 1;
            end
            if (e.hf && m_stall < 65535) m_stall++;
            if (e.we)
                ref_mem[cpu_wr_addr] = cpu_wr_half ?
                    {ref_mem[cpu_wr_addr][31:16], cpu_wr_data[15:0]} : cpu_wr_data;
        end
    endtask

    task automatic cyc(input bit we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                       input bit half, input bit rd, input logic [ADDR_W-1:0] ra,
                       input bit dq, input logic [ADDR_W-1:0] da);
        @(posedge clk);
        #1;
        in_RST = rst_lvl;
        cpu_we = we; cpu_wr_addr = wa; cpu_wr_data = wd; cpu_wr_half = half;
        cpu_rd_req = rd; cpu_rd_addr = ra; dbg_req = dq; dbg_addr = da;
        model_step(rst_lvl);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, '0, '0, 0, 0, '0, 0, '0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("hold_front", hold_front, e.hf);
            chk("hold_wb", hold_wb, e.hwb);
            chk("mem_we", mem_we, e.we);
            chk("mem_half", mem_half, e.half);
            chk("mem_wdata", mem_wdata, e.wdata);
            if (e.addr_care) chk("mem_addr", mem_addr, e.addr);
            if (e.rd_care) chk("cpu_rd_data", cpu_rd_data, e.rd_data);
            chk("dbg_ack", dbg_ack, e.ack);
            chk("dbg_data_hold", dbg_data, e.dbg_data);
            chk("stall_cnt", stall_cnt, e.stall);
        end
        if (dbg_ack === 1'b1) begin
            if (dbg_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL dbg_unexpected_ack: got ack with data 0x%0h, expected no ack", dbg_data);
            end else begin
                chk("dbg_reply", dbg_data, dbg_q.pop_front());
            end
        end
    end

    initial begin
        rst_lvl = 0;
        model_reset();
        idle(2);
        rst_lvl = 1;
        idle(1);

        // Idle debug read of a freshly stored word
        cyc(1, 12'h010, 32'hDEADBEEF, 0, 0, '0, 0, '0);
        idle(1);
        cyc(0, '0, '0, 0, 0, '0, 1, 12'h010);
        idle(3);
        chk("idle_dbg_data", dbg_data, 32'hDEADBEEF);

        // Debug read forced through continuous loads
        cyc(1, 12'h020, 32'hCAFE0020, 0, 0, '0, 0, '0);
        cyc(0, '0, '0, 0, 1, 12'h001, 1, 12'h020);
        for (int k = 0; k < 7; k++) cyc(0, '0, '0, 0, 1, 12'(k), 0, '0);
        idle(2);
        chk("forced_dbg_data", dbg_data, 32'hCAFE0020);
        chk("forced_stall", stall_cnt, 16'd1);

        // Store/load collision, load retried next cycle
        cyc(1, 12'h004, 32'h12345678, 0, 1, 12'h004, 0, '0);
        cyc(0, '0, '0, 0, 1, 12'h004, 0, '0);
        idle(1);

        // Forced read while a store is waiting, then halfword store
        cyc(1, 12'h008, 32'hA5A5A5A5, 0, 0, '0, 1, 12'h004);
        for (int k = 0; k < DBG_MAX_WAIT + 1; k++) cyc(1, 12'h008, 32'hA5A5A5A5, 0, 0, '0, 0, '0);
        cyc(1, 12'h008, 32'h0000BEEF, 1, 0, '0, 0, '0);
        cyc(0, '0, '0, 0, 1, 12'h008, 0, '0);
        idle(2);

        // Asynchronous reset in the middle of a WAIT
        cyc(0, '0, '0, 0, 1, 12'h003, 1, 12'h008);
        cyc(0, '0, '0, 0, 1, 12'h003, 0, '0);
        cyc(0, '0, '0, 0, 1, 12'h003, 0, '0);
        #2;
        in_RST = 1'b0;
        rst_lvl = 0;
        model_reset();
        void'(exp_q.pop_back());
        model_step(0);
        cyc(0, '0, '0, 0, 1, 12'h003, 0, '0);
        rst_lvl = 1;
        idle(4);
        chk("reset_stall", stall_cnt, 16'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit we, rd, dq, half;
            we   = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
            rd   = (i < 1500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
            dq   = ($urandom_range(0, 3) == 0);
            half = ($urandom_range(0, 4) == 0);
            cyc(we, 12'($urandom_range(0, 15)), $urandom, half,
                rd, 12'($urandom_range(0, 15)), dq, 12'($urandom_range(0, 15)));
        end
        idle(DBG_MAX_WAIT + 4);

        // Stall counter saturation
        while (m_stall < 16'hFFFE) cyc(1, 12'h00C, 32'h0, 0, 1, 12'h00C, 0, '0);
        idle(1);
        chk("stall_preload", stall_cnt, 16'hFFFE);
        for (int k = 0; k < 3; k++) cyc(1, 12'h00C, 32'h1, 0, 1, 12'h00C, 0, '0);
        idle(2);
        chk("stall_saturated", stall_cnt, 16'hFFFF);

        @(negedge clk);
        #1;
        chk("dbg_replies_outstanding", dbg_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mem_port_sched.md
# mem_port_sched

Scheduler for the single data-memory port shared by the pipeline's MEM-stage load, WB-stage store and the debug/display read port. Each cycle it decides who drives the memory address, write-enable and write data. It freezes pipeline stages when the port is taken from them, and bounds the debug reader's wait so the display always refreshes. It sits between the MEM/WB pipeline registers and the data-memory block, and its hold outputs feed the stage enables.

## Interface
- ADDR_W, 12, memory address width (word/byte addressing as in data memory)
- DATA_W, 32, data width
- DBG_MAX_WAIT, 4, cycles a pending debug read may be deferred before it is forced (>=1)
- clk  in  1  system clock, rising edge
- in_RST  in  1  reset, asynchronous, active-low
- cpu_we  in  1  WB-stage store request
- cpu_wr_addr  in  ADDR_W  store address
- cpu_wr_data  in  DATA_W  store data
- cpu_wr_half  in  1  halfword store mode
- cpu_rd_req  in  1  MEM-stage load request
- cpu_rd_addr  in  ADDR_W  load address
- cpu_rd_data  out  DATA_W  load data, combinational pass-through of mem_rdata
- hold_front  out  1  freeze IF..MEM stages this cycle
- hold_wb  out  1  freeze WB stage this cycle
- dbg_req  in  1  debug read request (level)
- dbg_addr  in  ADDR_W  debug read address
- dbg_ack  out  1  one-cycle pulse: dbg_data valid
- dbg_data  out  DATA_W  registered debug read data
- mem_we  out  1  memory write enable (write on clk edge)
- mem_half  out  1  memory halfword mode
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory combinational read data
- stall_cnt  out  16  saturating count of cycles with hold_front=1

## Operation
- States: IDLE (no debug pending), WAIT (debug latched, deferred), FORCE (debug owns port).
- Grant priority in IDLE and WAIT: store > load > debug.
- Owner drives mem_addr.
- mem_we=cpu_we and mem_half=cpu_wr_half only when the store is granted; otherwise mem_we=0.
- mem_wdata=cpu_wr_data always.
- Store and load in the same cycle (not FORCE):
  - Store granted.
  - hold_front=1, hold_wb=0: WB retires, the load retries next cycle.
- IDLE:
  - If dbg_req=1, latch dbg_addr into dbg_addr_q and go to WAIT. Debug is not served in the latch cycle.
- WAIT, cycle with cpu_we=0 and cpu_rd_req=0:
  - mem_addr=dbg_addr_q.
  - On the edge, dbg_data<=mem_rdata, dbg_ack<=1, wait_cnt<=0, go to IDLE.
- WAIT, cycle with any CPU request:
  - CPU is served and wait_cnt increments.
  - When wait_cnt==DBG_MAX_WAIT-1 at the edge, go to FORCE.
- FORCE:
  - mem_addr=dbg_addr_q, mem_we=0.
  - hold_front=cpu_rd_req|cpu_we, hold_wb=cpu_we.
  - On the edge, capture dbg_data, pulse dbg_ack, go to IDLE.
  - FORCE lasts exactly one cycle.
- dbg_req and dbg_addr are ignored outside IDLE.
- In the cycle dbg_ack=1 the state is IDLE. A still-high dbg_req is latched again, giving back-to-back requests.
- dbg_data holds its value until the next ack.
- cpu_rd_data=mem_rdata unconditionally. It is meaningful only when the load is granted; the pipeline is frozen otherwise.
- stall_cnt increments on each edge where hold_front=1 and saturates at 0xFFFF.

## Timing
- Reset (in_RST=0, asynchronous) sets:
  - state=IDLE, wait_cnt=0, dbg_addr_q=0, dbg_data=0, dbg_ack=0, stall_cnt=0.
  - Combinational outputs follow the IDLE rules.
  - A pending debug request is dropped with no ack.
- hold_front, hold_wb, mem_* and cpu_rd_data are combinational from inputs and state, with zero latency.
- Debug latency from the latch edge to dbg_ack high:
  - 1 cycle if the port is free in the next cycle.
  - At most DBG_MAX_WAIT+1 cycles when the CPU occupies the port continuously.
- Holds last at most one cycle per forced debug read.
- A store/load collision costs exactly one hold_front cycle.

## Test plan
- Idle debug read:
  - Stimulus: memory word 0x010 = 0xDEADBEEF; dbg_req=1, dbg_addr=0x010 for one cycle, no CPU traffic.
  - Required: latched at edge 1, dbg_ack at edge 2 with dbg_data=0xDEADBEEF, hold_front never asserted.
- Forced debug read:
  - Stimulus: DBG_MAX_WAIT=4; cpu_rd_req=1 every cycle, debug request to 0x020.
  - Required: WAIT for 4 cycles, then FORCE with hold_front=1, hold_wb=0 for one cycle, dbg_ack the next cycle, stall_cnt=1.
- Store/load collision:
  - Stimulus: cpu_we=1 (addr 0x004, data 0x12345678) and cpu_rd_req=1 (addr 0x004) in the same cycle.
  - Required: mem_we=1, hold_front=1, hold_wb=0. Next cycle the load returns 0x12345678.
- Forced read during a store:
  - Stimulus: FORCE entered while cpu_we=1.
  - Required: mem_we=0, hold_wb=1, hold_front=1. The store executes in the following cycle.
- Reset mid-WAIT:
  - Stimulus: assert in_RST=0 asynchronously mid-cycle while in WAIT.
  - Required: state IDLE immediately, dbg_ack never pulses, stall_cnt=0.
- Saturation:
  - Stimulus: preload stall_cnt to 0xFFFE, then 3 hold_front cycles.
  - Required: stall_cnt=0xFFFF, with no wrap.
